// File: rtl/nonce_result_scan_pkg.sv
// Shared definitions for the nonce result scanner.
//   scan_state_t : scan controller states
//   RESULT_WORDS : length of the result record written back to memory
//   OFF_*        : word offsets of each field inside the result record
package nonce_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } scan_state_t;

    localparam int          RESULT_WORDS = 3;
    localparam logic [15:0] OFF_COUNT    = 16'd0;
    localparam logic [15:0] OFF_NONCE    = 16'd1;
    localparam logic [15:0] OFF_HASH     = 16'd2;

endpackage

// File: rtl/nonce_result_scan_if.sv
// Word-addressed shared memory port used by the nonce result scanner.
//   mem_clk        : memory clock (driven from the master's clk)
//   mem_we         : write enable
//   mem_addr       : word address
//   mem_write_data : write data
//   mem_read_data  : read data, valid the cycle after its address
interface nonce_result_scan_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scan_min_tracker.sv
// Running minimum / hit tracker for a stream of hash words.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : restart tracking (next valid word becomes the first word)
//   valid       : data/index carry a word this cycle
//   data, index : hash word and its nonce index
//   target      : difficulty target; data < target counts as a hit
//   best_value, best_index, hit_count : running result INCLUDING the word
//                 presented this cycle, so the caller can capture the final
//                 result in the same cycle the last word arrives.
module scan_min_tracker #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      data,
    input  logic [7:0]       index,
    input  logic [31:0]      target,
    output logic [31:0]      best_value,
    output logic [7:0]       best_index,
    output logic [CNT_W-1:0] hit_count
);

    logic             first_reg;
    logic [31:0]      best_value_reg;
    logic [7:0]       best_index_reg;
    logic [CNT_W-1:0] hit_count_reg;

    logic take;
    logic hit;

    // Strict less-than on both compares: a tie with the current best keeps
    // the earlier (lower) nonce, and a word equal to target is not a hit.
    always_comb begin
        take       = valid && (first_reg || (data < best_value_reg));
        hit        = valid && (data < target);
        best_value = take ? data  : best_value_reg;
        best_index = take ? index : best_index_reg;
        hit_count  = hit_count_reg + CNT_W'(hit);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            first_reg      <= 1'b1;
            best_value_reg <= '0;
            best_index_reg <= '0;
            hit_count_reg  <= '0;
        end else if (valid) begin
            first_reg      <= 1'b0;
            best_value_reg <= best_value;
            best_index_reg <= best_index;
            hit_count_reg  <= hit_count;
        end
    end

endmodule

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES consecutive H0 words from memory, tracks the lowest hash
// and the number of words below target, then writes a 3-word result record
// {hit_count, best_nonce, best_hash} at result_addr.
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle request, accepted only when idle
//   hash_addr           : word address of nonce 0's H0 word
//   result_addr, target : record address and difficulty target
//   done                : high while idle
//   found, best_nonce, best_hash, hit_count : result of last completed scan
//   mem                 : shared memory port (master side)
module nonce_result_scan
    import nonce_scan_pkg::*;
#(
    parameter  int NUM_NONCES = 16,
    localparam int CNT_W      = $clog2(NUM_NONCES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        hash_addr,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [7:0]         best_nonce,
    output logic [31:0]        best_hash,
    output logic [CNT_W-1:0]   hit_count,
    nonce_result_scan_if.master mem
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_WRITE = WRITE;

    localparam logic [7:0] LAST_IDX   = 8'(NUM_NONCES - 1);
    localparam logic [1:0] LAST_WRITE = 2'(RESULT_WORDS - 1);

    logic [1:0]       state_reg;
    logic [15:0]      result_addr_reg;
    logic [31:0]      target_reg;
    logic [7:0]       cnt_reg;
    logic             rd_valid_reg;
    logic [7:0]       rd_idx_reg;
    logic [1:0]       wr_cnt_reg;
    logic             mem_we_reg;
    logic [15:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic             found_reg;
    logic [7:0]       best_nonce_reg;
    logic [31:0]      best_hash_reg;
    logic [CNT_W-1:0] hit_count_reg;

    logic             trk_clear;
    logic [31:0]      trk_best;
    logic [7:0]       trk_idx;
    logic [CNT_W-1:0] trk_hits;

    assign trk_clear = (state_reg == ST_IDLE) && start;

    // Read data lags its address by one cycle, so valid/index are the
    // READ-state flag and counter delayed by one cycle.
    scan_min_tracker #(.CNT_W(CNT_W)) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (trk_clear),
        .valid      (rd_valid_reg),
        .data       (mem.mem_read_data),
        .index      (rd_idx_reg),
        .target     (target_reg),
        .best_value (trk_best),
        .best_index (trk_idx),
        .hit_count  (trk_hits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            result_addr_reg <= '0;
            target_reg      <= '0;
            cnt_reg         <= '0;
            rd_valid_reg    <= 1'b0;
            rd_idx_reg      <= '0;
            wr_cnt_reg      <= '0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            found_reg       <= 1'b0;
            best_nonce_reg  <= '0;
            best_hash_reg   <= '0;
            hit_count_reg   <= '0;
        end else begin
            rd_valid_reg <= (state_reg == ST_READ);
            rd_idx_reg   <= cnt_reg;
            case (state_reg)
                ST_IDLE: begin
                    mem_we_reg <= 1'b0;
                    if (start) begin
                        result_addr_reg <= result_addr;
                        target_reg      <= target;
                        mem_addr_reg    <= hash_addr;
                        cnt_reg         <= '0;
                        state_reg       <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        cnt_reg      <= cnt_reg + 8'd1;
                        mem_addr_reg <= mem_addr_reg + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    // The tracker's combinational view already includes the
                    // last word here, so results and the first record word
                    // are captured together.
                    state_reg      <= ST_WRITE;
                    wr_cnt_reg     <= '0;
                    mem_we_reg     <= 1'b1;
                    mem_addr_reg   <= result_addr_reg + OFF_COUNT;
                    mem_wdata_reg  <= {{(32-CNT_W){1'b0}}, trk_hits};
                    found_reg      <= (trk_hits != '0);
                    best_nonce_reg <= trk_idx;
                    best_hash_reg  <= trk_best;
                    hit_count_reg  <= trk_hits;
                end
                ST_WRITE: begin
                    if (wr_cnt_reg == LAST_WRITE) begin
                        mem_we_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        wr_cnt_reg <= wr_cnt_reg + 2'd1;
                        if (wr_cnt_reg == 2'd0) begin
                            mem_addr_reg  <= result_addr_reg + OFF_NONCE;
                            mem_wdata_reg <= {24'd0, best_nonce_reg};
                        end else begin
                            mem_addr_reg  <= result_addr_reg + OFF_HASH;
                            mem_wdata_reg <= best_hash_reg;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign done               = (state_reg == ST_IDLE);
    assign found              = found_reg;
    assign best_nonce         = best_nonce_reg;
    assign best_hash          = best_hash_reg;
    assign hit_count          = hit_count_reg;
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = mem_we_reg;
    assign mem.mem_addr       = mem_addr_reg;
    assign mem.mem_write_data = mem_wdata_reg;

endmodule
